// File: rtl/demux_1to4.sv
// demux_1to4: registered 1-to-4 demultiplexer with saturating per-channel transfer counters
module demux_1to4 #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [3:0]       out_valid,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
    output logic [CNT_W-1:0] cnt3
);
    logic [3:0]       hit;
    logic [WIDTH-1:0] o [4];
    logic [CNT_W-1:0] c [4];
    always_comb hit = in_valid ? 4'b0001 << sel : 4'b0000;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= '0;
            for (int i = 0; i < 4; i++) begin
                o[i] <= '0;
                c[i] <= '0;
            end
        end else begin
            out_valid <= hit;
            for (int i = 0; i < 4; i++) begin
                o[i] <= hit[i] ? in : '0;
                if (hit[i] && c[i] != '1) c[i] <= c[i] + CNT_W'(1);
            end
        end
    end
    assign out0 = o[0];
    assign out1 = o[1];
    assign out2 = o[2];
    assign out3 = o[3];
    assign cnt0 = c[0];
    assign cnt1 = c[1];
    assign cnt2 = c[2];
    assign cnt3 = c[3];
endmodule

// File: tb/tb_demux_1to4.sv
// tb_demux_1to4: randomized and directed checks of demux_1to4 against a behavioural model
module tb_demux_1to4;
    localparam int W = 8;
    localparam int CW = 8;
    localparam int CMAX = (1 << CW) - 1;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  in = '0;
    logic          in_valid = 1'b0;
    logic [1:0]    sel = '0;
    logic [W-1:0]  out0, out1, out2, out3;
    logic [3:0]    out_valid;
    logic [CW-1:0] cnt0, cnt1, cnt2, cnt3;
    int tests = 0;
    int fails = 0;
    int exp_out [4];
    int exp_v;
    int exp_cnt [4];

    demux_1to4 #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in(in), .in_valid(in_valid), .sel(sel),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3), .out_valid(out_valid),
        .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_v = 0;
        for (int k = 0; k < 4; k++) begin
            exp_out[k] = 0;
            exp_cnt[k] = 0;
        end
    endtask

    task automatic check_all(input string tag);
        logic [W-1:0]  o [4];
        logic [CW-1:0] c [4];
        int nz;
        o = '{out0, out1, out2, out3};
        c = '{cnt0, cnt1, cnt2, cnt3};
        nz = 0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s out%0d", tag, k), 32'(o[k]), 32'(exp_out[k]));
            check($sformatf("%s cnt%0d", tag, k), 32'(c[k]), 32'(exp_cnt[k]));
            if (o[k] != '0) nz++;
        end
        check({tag, " out_valid"}, 32'(out_valid), 32'(exp_v));
        check({tag, " onehot"}, 32'($countones(out_valid) <= 1), 32'(1));
        check({tag, " one_nonzero"}, 32'(nz <= 1), 32'(1));
    endtask

    // Model update at the sampling edge, then compare just after it.
    task automatic commit(input string tag);
        int d, s;
        bit v;
        @(posedge clk);
        d = int'(in);
        v = in_valid;
        s = int'(sel);
        for (int k = 0; k < 4; k++) exp_out[k] = (v && s == k) ? d : 0;
        exp_v = v ? (1 << s) : 0;
        if (v && exp_cnt[s] < CMAX) exp_cnt[s] = exp_cnt[s] + 1;
        #1 check_all(tag);
    endtask

    task automatic step(input string tag, input int d, input bit v, input int s);
        @(negedge clk);
        in = W'(d);
        in_valid = v;
        sel = 2'(s);
        commit(tag);
    endtask

    initial begin
        model_reset();
        #12 check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        in = 8'd1;
        in_valid = 1'b1;
        sel = 2'd0;
        commit("first_xfer");
        for (int r = 0; r < 2; r++)
            for (int s = (r == 0 ? 1 : 0); s < 4; s++) step($sformatf("walk sel%0d", s), 1, 1'b1, s);
        step("zero_data", 0, 1'b1, 3);
        step("invalid", 1, 1'b0, 2);
        for (int i = 0; i < 8; i++) step("alt_a5", 'hA5, 1'b1, (i % 2) * 3);
        step("pre_rst", 1, 1'b1, 2);
        #2 rst_n = 1'b0;
        in_valid = 1'b0;
        model_reset();
        #1 check_all("async_rst");
        @(posedge clk);
        #1 check_all("held_rst");
        @(negedge clk);
        rst_n = 1'b1;
        in = 8'd1;
        in_valid = 1'b1;
        sel = 2'd0;
        commit("release");
        for (int i = 0; i < 200; i++)
            step("random", (i % 17 == 0) ? 0 : int'($urandom_range(0, 255)),
                 bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)));
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        model_reset();
        #1 check_all("rst2");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 300; i++) step("saturate", 'h3C, 1'b1, 1);
        check("sat cnt1", 32'(cnt1), 32'(CMAX));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
